// File: rtl/watering_request_ctrl_if.sv
// Handshake bundle between the moisture front end and watering_request_ctrl.
// manual_water exists only when MANUAL_OVERRIDE_EN is defined.
interface watering_request_ctrl_if #(
  parameter int MOIST_W = 8
);
  logic [MOIST_W-1:0] moisture;
  logic               moisture_valid;
  logic               tank_empty;
  logic               fault_clear;
`ifdef MANUAL_OVERRIDE_EN
  logic               manual_water;
`endif
  logic               watering;
  logic               timeout_fault;
  logic [1:0]         state_o;

  modport master (
`ifdef MANUAL_OVERRIDE_EN
    output manual_water,
`endif
    output moisture, moisture_valid, tank_empty, fault_clear,
    input  watering, timeout_fault, state_o
  );

  modport slave (
`ifdef MANUAL_OVERRIDE_EN
    input  manual_water,
`endif
    input  moisture, moisture_valid, tank_empty, fault_clear,
    output watering, timeout_fault, state_o
  );
endinterface

// File: rtl/watering_request_ctrl.sv
// Debounced, hysteretic, time-capped watering request with cooldown and timeout fault.
// Optional MANUAL_OVERRIDE_EN: manual_water forces WATERING from IDLE or COOLDOWN.
module watering_request_ctrl #(
  parameter int MOIST_W       = 8,
  parameter int LOW_TH        = 60,
  parameter int HIGH_TH       = 140,
  parameter int DEBOUNCE      = 3,
  parameter int MAX_WATER_CYC = 1000,
  parameter int COOLDOWN_CYC  = 500
) (
  input logic                    i_clock,
  input logic                    i_reset,
  watering_request_ctrl_if.slave bus
);
  localparam int TMAX = (MAX_WATER_CYC > COOLDOWN_CYC) ? MAX_WATER_CYC : COOLDOWN_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(DEBOUNCE + 1);

  localparam logic [MOIST_W-1:0] LOW_V    = MOIST_W'(LOW_TH);
  localparam logic [MOIST_W-1:0] HIGH_V   = MOIST_W'(HIGH_TH);
  localparam logic [DW-1:0]      D_SAT    = DW'(DEBOUNCE);
  localparam logic [TW-1:0]      T_WATER  = TW'(MAX_WATER_CYC - 1);
  localparam logic [TW-1:0]      T_COOL   = TW'(COOLDOWN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WATER = 2'b01,
    ST_COOL  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_dry_cnt, w_dry_nxt;
  logic [TW-1:0] r_timer;
  logic          w_dry, w_wet, w_manual;

  assign w_dry = bus.moisture_valid && (bus.moisture < LOW_V);
  assign w_wet = bus.moisture_valid && (bus.moisture >= HIGH_V);
`ifdef MANUAL_OVERRIDE_EN
  assign w_manual = bus.manual_water;
`else
  assign w_manual = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_dry_nxt   = r_dry_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.moisture_valid)
          w_dry_nxt = w_dry ? ((r_dry_cnt == D_SAT) ? D_SAT : r_dry_cnt + DW'(1)) : '0;
        // A saturated count waits here until the tank refills.
        if (!bus.tank_empty && (w_dry_nxt == D_SAT || w_manual))
          w_state_nxt = ST_WATER;
      end
      ST_WATER: begin
        if (w_wet || bus.tank_empty) w_state_nxt = ST_COOL;
        else if (r_timer == T_WATER) w_state_nxt = ST_FAULT;
      end
      ST_COOL: begin
        if (w_manual && !bus.tank_empty) w_state_nxt = ST_WATER;
        else if (r_timer == T_COOL)      w_state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        if (bus.fault_clear) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != ST_IDLE) w_dry_nxt = '0;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_dry_cnt <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dry_cnt <= w_dry_nxt;
      if (w_state_nxt != r_state) r_timer <= '0;
      else if (r_timer != {TW{1'b1}}) r_timer <= r_timer + TW'(1);
    end
  end

  assign bus.watering      = (r_state == ST_WATER);
  assign bus.timeout_fault = (r_state == ST_FAULT);
  assign bus.state_o       = r_state;
endmodule
